// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-to-RAM slave.
// Command codes travel in rx_data[9:8]; the slave forwards them untouched.
package spi_ram_pkg;

   localparam int RX_W_DEF = 10;
   localparam int TX_W_DEF = 8;
   localparam int TX_BITS  = 8;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } spi_state_e;

   // Progress through a frame once the command bit has routed it.
   typedef enum logic [2:0] {
      PH_SHIFT,
      PH_LOAD,
      PH_WAIT,
      PH_SEND,
      PH_HOLD
   } spi_phase_e;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the RAM-side word/strobe bundle.
// master drives the serial lines and the RAM read data.
interface spi_slave_if
   import spi_ram_pkg::*;
#(
   parameter int RX_W = RX_W_DEF,
   parameter int TX_W = TX_W_DEF
);

   logic            SS_n;
   logic            MOSI;
   logic            MISO;
   logic [RX_W-1:0] rx_data;
   logic            rx_valid;
   logic [TX_W-1:0] tx_data;
   logic            tx_valid;

   modport slave (
      input  SS_n,
      input  MOSI,
      input  tx_data,
      input  tx_valid,
      output MISO,
      output rx_data,
      output rx_valid
   );

   modport master (
      output SS_n,
      output MOSI,
      output tx_data,
      output tx_valid,
      input  MISO,
      input  rx_data,
      input  rx_valid
   );

endinterface

// File: rtl/spi_slave.sv
// SPI slave: deserialises 10-bit RAM commands, serialises 8-bit read data.
// Everything runs on clk; MOSI is sampled on every rising edge.
module spi_slave
   import spi_ram_pkg::*;
#(
   parameter int RX_W = RX_W_DEF,
   parameter int TX_W = TX_W_DEF
) (
   input logic        clk,
   input logic        rst,
   spi_slave_if.slave bus
);

   localparam logic [3:0] LAST_BIT = 4'(RX_W - 1);

   spi_state_e      state;
   spi_state_e      state_nxt;
   spi_phase_e      phase;
   logic [RX_W-1:0] shreg;
   logic [RX_W-1:0] rx_word;
   logic            rx_strobe;
   logic            miso_bit;
   logic            rd_addr_seen;
   logic [3:0]      bit_cnt;
   logic [2:0]      tx_cnt;
   logic [TX_W-1:0] tx_word;
   logic            in_frame;

   assign bus.rx_data  = rx_word;
   assign bus.rx_valid = rx_strobe;
   assign bus.MISO     = miso_bit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (bus.SS_n) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               state_nxt = CHK_CMD;
            end
            CHK_CMD: begin
               if (!bus.MOSI) begin
                  state_nxt = WRITE;
               end else if (rd_addr_seen) begin
                  state_nxt = READ_DATA;
               end else begin
                  state_nxt = READ_ADD;
               end
            end
            default: begin
               state_nxt = state;
            end
         endcase
      end
   end

   // Payload handling only happens once the command bit has picked a path.
   assign in_frame = !bus.SS_n
                  && (state != IDLE)
                  && (state != CHK_CMD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase        <= PH_SHIFT;
         shreg        <= '0;
         rx_word      <= '0;
         rx_strobe    <= 1'b0;
         miso_bit     <= 1'b0;
         rd_addr_seen <= 1'b0;
         bit_cnt      <= '0;
         tx_cnt       <= '0;
         tx_word      <= '0;
      end else begin
         rx_strobe <= 1'b0;
         if (!in_frame) begin
            phase    <= PH_SHIFT;
            bit_cnt  <= '0;
            tx_cnt   <= '0;
            miso_bit <= 1'b0;
         end else begin
            unique case (phase)
               PH_SHIFT: begin
                  shreg <= {shreg[RX_W-2:0], bus.MOSI};
                  if (bit_cnt == LAST_BIT) begin
                     phase <= PH_LOAD;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
               PH_LOAD: begin
                  rx_word   <= shreg;
                  rx_strobe <= 1'b1;
                  if (state == READ_ADD) begin
                     rd_addr_seen <= 1'b1;
                  end
                  phase <= (state == READ_DATA) ? PH_WAIT : PH_HOLD;
               end
               PH_WAIT: begin
                  if (bus.tx_valid) begin
                     tx_word      <= bus.tx_data;
                     tx_cnt       <= 3'd7;
                     miso_bit     <= bus.tx_data[TX_BITS-1];
                     rd_addr_seen <= 1'b0;
                     phase        <= PH_SEND;
                  end
               end
               PH_SEND: begin
                  // tx_cnt names the bit currently on MISO.
                  if (tx_cnt == 3'd0) begin
                     miso_bit <= 1'b0;
                     phase    <= PH_HOLD;
                  end else begin
                     tx_cnt   <= tx_cnt - 3'd1;
                     miso_bit <= tx_word[tx_cnt - 3'd1];
                  end
               end
               PH_HOLD: begin
                  miso_bit <= 1'b0;
               end
               default: begin
                  phase <= PH_HOLD;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Directed scoreboard bench for spi_slave.
// Expected rx words and MISO bits are queued as stimulus is driven.
module tb_spi_slave;
   import spi_ram_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic [9:0] rxq[$];
   logic       misoq[$];

   spi_slave_if bus ();

   spi_slave dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic cmd, input logic [9:0] word,
                       input int nbits);
      bus.SS_n = 1'b0;
      tick();
      bus.MOSI = cmd;
      tick();
      for (int i = 0; i < nbits; i++) begin
         bus.MOSI = word[9-i];
         tick();
      end
      bus.MOSI = 1'($urandom);
      if (nbits == 10) rxq.push_back(word);
   endtask

   task automatic expect_rx(input string tag);
      logic [9:0] exp;
      int n;
      n = 0;
      chk({tag, "_early"}, 32'(bus.rx_valid), 32'd0);
      tick();
      while (!bus.rx_valid && n < 4) begin
         tick();
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'd0);
      exp = (rxq.size() > 0) ? rxq.pop_front() : 10'h000;
      chk({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
      chk({tag, "_data"}, 32'(bus.rx_data), 32'(exp));
      tick();
      chk({tag, "_pulse"}, 32'(bus.rx_valid), 32'd0);
   endtask

   task automatic end_frame(input string tag);
      bus.SS_n = 1'b1;
      tick();
      chk({tag, "_idle"}, 32'(dut.state), 32'(IDLE));
      chk({tag, "_miso"}, 32'(bus.MISO), 32'd0);
   endtask

   task automatic push_tx(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) misoq.push_back(d[i]);
   endtask

   task automatic check_miso(input string tag, input int nbits);
      logic e;
      for (int i = 0; i < nbits; i++) begin
         e = (misoq.size() > 0) ? misoq.pop_front() : 1'b0;
         chk(tag, 32'(bus.MISO), 32'(e));
         if (i < nbits - 1) tick();
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.SS_n      = 1'b1;
      bus.MOSI      = 1'b0;
      bus.tx_data   = '0;
      bus.tx_valid  = 1'b0;

      #2;
      chk("rst_state", 32'(dut.state), 32'(IDLE));
      chk("rst_miso", 32'(bus.MISO), 32'd0);
      chk("rst_valid", 32'(bus.rx_valid), 32'd0);
      chk("rst_data", 32'(bus.rx_data), 32'd0);
      chk("rst_seen", 32'(dut.rd_addr_seen), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_idle", 32'(dut.state), 32'(IDLE));

      // write address: first SS_n sample to rx_valid is 12 edges
      send(1'b0, 10'h0A5, 10);
      expect_rx("wr_addr");
      chk("wr_addr_state", 32'(dut.state), 32'(WRITE));
      for (int i = 0; i < 4; i++) begin
         bus.MOSI = 1'(i);
         tick();
         chk("hold_novalid", 32'(bus.rx_valid), 32'd0);
      end
      end_frame("wr_addr");

      // spurious tx_valid during a write frame
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'hFF;
      send(1'b0, {CMD_WR_DATA, 8'h3C}, 10);
      chk("spur_miso_a", 32'(bus.MISO), 32'd0);
      expect_rx("wr_data");
      for (int i = 0; i < 6; i++) begin
         bus.tx_valid = ~bus.tx_valid;
         tick();
         chk("spur_miso", 32'(bus.MISO), 32'd0);
      end
      bus.tx_valid = 1'b0;
      chk("spur_seen", 32'(dut.rd_addr_seen), 32'd0);
      end_frame("spur");

      // read address then read data
      send(1'b1, {CMD_RD_ADDR, 8'h03}, 10);
      expect_rx("rd_addr");
      chk("rd_addr_state", 32'(dut.state), 32'(READ_ADD));
      chk("rd_addr_seen", 32'(dut.rd_addr_seen), 32'd1);
      end_frame("rd_addr");

      send(1'b1, {CMD_RD_DATA, 8'hA7}, 10);
      expect_rx("rd_data");
      chk("rd_data_state", 32'(dut.state), 32'(READ_DATA));
      tick();
      chk("wait_miso", 32'(bus.MISO), 32'd0);
      chk("wait_seen", 32'(dut.rd_addr_seen), 32'd1);
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'hC6;
      push_tx(8'hC6);
      tick();
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      chk("cap_seen", 32'(dut.rd_addr_seen), 32'd0);
      check_miso("miso_c6", 8);
      tick();
      chk("miso_done", 32'(bus.MISO), 32'd0);
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("late_tx_miso", 32'(bus.MISO), 32'd0);
      end
      bus.tx_valid = 1'b0;
      end_frame("rd_data");

      // read data with no prior address is routed to READ_ADD
      send(1'b1, 10'h3FF, 10);
      expect_rx("order");
      chk("order_state", 32'(dut.state), 32'(READ_ADD));
      chk("order_seen", 32'(dut.rd_addr_seen), 32'd1);
      end_frame("order");

      // abort after 5 payload bits
      send(1'b0, 10'h2AA, 5);
      bus.SS_n = 1'b1;
      tick();
      chk("abort_idle", 32'(dut.state), 32'(IDLE));
      chk("abort_valid", 32'(bus.rx_valid), 32'd0);
      chk("abort_seen", 32'(dut.rd_addr_seen), 32'd1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("abort_novalid", 32'(bus.rx_valid), 32'd0);
      end
      send(1'b0, {CMD_WR_DATA, 8'h5A}, 10);
      expect_rx("after_abort");
      end_frame("after_abort");

      // reset while MISO carries bit 3
      send(1'b1, {CMD_RD_DATA, 8'h55}, 10);
      expect_rx("rst_rd");
      chk("rst_rd_state", 32'(dut.state), 32'(READ_DATA));
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'h5A;
      push_tx(8'h5A);
      tick();
      bus.tx_valid = 1'b0;
      check_miso("miso_5a", 5);
      #2;
      rst      = 1'b1;
      bus.SS_n = 1'b1;
      misoq.delete();
      #1;
      chk("mid_rst_miso", 32'(bus.MISO), 32'd0);
      chk("mid_rst_valid", 32'(bus.rx_valid), 32'd0);
      chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
      chk("mid_rst_seen", 32'(dut.rd_addr_seen), 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("post_rst_miso", 32'(bus.MISO), 32'd0);
         chk("post_rst_valid", 32'(bus.rx_valid), 32'd0);
      end
      chk("post_rst_wait", 32'(dut.state), 32'(IDLE));

      send(1'b0, {CMD_WR_ADDR, 8'hC3}, 10);
      expect_rx("final");
      end_frame("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have parameter RX_W, default 10, meaning the width of the parallel word sent to the RAM.
REQ-002 The block SHALL have parameter TX_W, default 8, meaning the width of the read data returned by the RAM.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port SS_n  input  1  SPI slave select, active-low; a high level ends the frame.
REQ-006 The block SHALL have port MOSI  input  1  serial data from the master, sampled on every clk rising edge.
REQ-007 The block SHALL have port MISO  output  1  serial read data to the master.
REQ-008 The block SHALL have port rx_data  output  RX_W  word to the RAM (din); bits [9:8] carry the command: 00 write address, 01 write data, 10 read address, 11 read data.
REQ-009 The block SHALL have port rx_valid  output  1  one-cycle strobe that qualifies rx_data.
REQ-010 The block SHALL have port tx_data  input  TX_W  read data from the RAM (dout).
REQ-011 The block SHALL have port tx_valid  input  1  qualifies tx_data.

Function
REQ-012 The FSM SHALL have the states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-013 IDLE SHALL move to CHK_CMD on the first edge where SS_n=0.
REQ-014 In CHK_CMD, a sampled MOSI=0 SHALL move the FSM to WRITE.
REQ-015 In CHK_CMD, a sampled MOSI=1 SHALL move the FSM to READ_ADD if rd_addr_seen=0 and to READ_DATA if rd_addr_seen=1.
REQ-016 In WRITE, READ_ADD and READ_DATA, the next 10 MOSI bits SHALL be shifted in MSB first, with the first bit becoming rx_data[9].
REQ-017 The edge after the 10th bit SHALL load rx_data and assert rx_valid for exactly one cycle, with rx_data held stable until the next load.
REQ-018 rx_data SHALL be forwarded verbatim, with no check of the command bits against the state.
REQ-019 In READ_ADD, the rx_valid strobe SHALL set rd_addr_seen to 1.
REQ-020 In READ_DATA, after rx_valid, the block SHALL wait for tx_valid, capture tx_data on the edge where tx_valid=1, and clear rd_addr_seen on that same edge.
REQ-021 MISO SHALL drive captured bits [7:0] MSB first, one bit per cycle, starting the cycle after capture; after 8 bits MISO SHALL return to 0.
REQ-022 Any tx_valid seen outside the READ_DATA wait phase SHALL be ignored.
REQ-023 After a frame completes, the FSM SHALL stay in its state, ignoring MOSI, until SS_n=1.
REQ-024 SS_n=1 sampled in any state SHALL return the FSM to IDLE on that edge, clear the bit and tx counters, and drive MISO to 0.
REQ-025 An SS_n abort SHALL produce no rx_valid for a partial frame and SHALL leave rd_addr_seen unchanged.
REQ-026 The bit counter SHALL be 4 bits wide, count 0..9, and be cleared on entry to CHK_CMD.
REQ-027 The tx counter SHALL be 3 bits wide and count 7 down to 0.
REQ-028 While the FSM is in IDLE or CHK_CMD, MISO SHALL be 0.

Reset
REQ-029 While rst=1, the block SHALL hold state=IDLE, rx_data=0, rx_valid=0, MISO=0, rd_addr_seen=0, and both counters and the shift register at 0, immediately and independent of clk.
REQ-030 Reset asserted mid-frame SHALL discard the frame, with no rx_valid pulse and no MISO bits after reset.
REQ-031 After rst deasserts, the block SHALL accept a new frame only after it has seen SS_n=0 in IDLE.

Structure
REQ-032 The state enum (spi_state_e), the command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10 and CMD_RD_DATA=2'b11, and the RX_W/TX_W defaults SHALL live in the shared package spi_ram_pkg.
REQ-033 The block SHALL have no sub-module; the shift register and counters SHALL be inline.
REQ-034 The state register SHALL be separated from next-state logic.

Verification
REQ-035 The bench SHALL check this write-address case: SS_n falls, MOSI=0, then bits 00_1010_0101 -> rx_data=10'h0A5 and rx_valid high for exactly 1 cycle, 12 edges after SS_n is first sampled low.
REQ-036 The bench SHALL check this read sequence: a read-address frame 10_0000_0011 (rx_data=10'h203, rd_addr_seen=1), SS_n high, then a read-data frame 11_xxxxxxxx with the RAM returning tx_data=8'hC6 -> MISO=1,1,0,0,0,1,1,0 on consecutive cycles after tx_valid, then rd_addr_seen=0.
REQ-037 The bench SHALL check this abort case: SS_n rises after 5 payload bits -> no rx_valid, state=IDLE on the next edge, and the next full frame is decoded correctly.
REQ-038 The bench SHALL check this reset case: rst pulsed during MISO bit 3 -> MISO=0 and rx_valid=0 immediately, with no further MISO toggles.
REQ-039 The bench SHALL check this ordering case: a read-data frame sent with rd_addr_seen=0 -> routed to READ_ADD and rd_addr_seen=1 after rx_valid.
REQ-040 The bench SHALL check this spurious-tx case: tx_valid pulsed during a WRITE frame -> ignored, with MISO remaining 0.
